seq_divider: RTL and testbench

Sequential unsigned restoring divider: WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock. It is the inverse-operation companion to the combinational adder/subtractor datapath. It reuses that add/subtract function in subtract mode for each trial subtraction. It sits behind a start/done handshake so a controller can issue one division at a time.

---
 rtl/seq_divider_pkg.sv | 17 +
 rtl/seq_divider_if.sv | 30 +++
 rtl/seq_divider_add_sub_unit.sv | 30 +++
 rtl/seq_divider.sv | 116 +++++++++++
 tb/tb_seq_divider.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_divider_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seq_divider_pkg : shared state encoding and default width.       |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package seq_divider_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seq_divider_if : start/done handshake plus operands and results. |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider_add_sub_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | add_sub_unit : N-bit ripple adder/subtractor (mode=1 subtracts). |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module add_sub_unit #(
  parameter int N = 9
) (
  input  wire logic [N-1:0] a,
  input  wire logic [N-1:0] b,
  input  wire logic         mode,
  output logic      [N-1:0] sum,
  output logic              cout
);
  logic [N:0] carry;

  assign carry[0] = mode;

  generate
    for (genvar i = 0; i < N; i++) begin : g_bit
      logic b_eff;
      assign b_eff        = b[i] ^ mode;
      assign sum[i]       = a[i] ^ b_eff ^ carry[i];
      assign carry[i + 1] = (a[i] & b_eff) | (carry[i] & (a[i] ^ b_eff));
    end
  endgenerate

  assign cout = carry[N];
endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | seq_divider : restoring unsigned divider, one quotient bit/clock.|
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire logic     clk,
  input  wire logic     rst,
  seq_divider_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             no_borrow;
  logic             last;
  logic             zero_div;
  logic             unused_msb;

  // R never exceeds D after a step, so only its low WIDTH bits are kept;
  // the shifted value still needs WIDTH+1 bits to hold the dividend MSB.
  assign r_shift  = {r, q[WIDTH-1]};
  assign r_next   = no_borrow ? trial : r_shift;
  assign q_next   = {q[WIDTH-2:0], no_borrow};
  assign last     = (count == CW'(WIDTH - 1));
  assign zero_div = (bus.divisor == '0);
  assign unused_msb = r_next[WIDTH];

  add_sub_unit #(
    .N (WIDTH + 1)
  ) u_trial (
    .a    (r_shift),
    .b    ({1'b0, d}),
    .mode (1'b1),
    .sum  (trial),
    .cout (no_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (bus.start) state_next = zero_div ? ST_DONE : ST_RUN;
      ST_RUN:  if (last)      state_next = ST_DONE;
      ST_DONE:                state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= '0;
      r           <= '0;
      d           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (zero_div) begin
              quotient    <= '1;
              remainder   <= bus.dividend;
              div_by_zero <= 1'b1;
            end else begin
              q           <= bus.dividend;
              r           <= '0;
              d           <= bus.divisor;
              count       <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          q     <= q_next;
          r     <= r_next[WIDTH-1:0];
          count <= count + CW'(1);
          if (last) begin
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == ST_RUN);
  assign bus.done        = (state == ST_DONE);
  assign bus.quotient    = quotient;
  assign bus.remainder   = remainder;
  assign bus.div_by_zero = div_by_zero;
endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_seq_divider : self-checking bench against an arithmetic model.|
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module tb_seq_divider;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: integer division; divide-by-zero saturates quotient.
  // Latency counted in falling edges after the accepting rising edge.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int dz, output int lat);
    if (b == 0) begin
      q = (1 << W) - 1; r = a; dz = 1; lat = 1;
    end else begin
      q = a / b; r = a % b; dz = 0; lat = W + 1;
    end
  endfunction

  task automatic do_div(input int a, input int b, output int lat, output int busy_n,
                        output int q, output int r, output int dz, output int after_done);
    lat = -1; busy_n = 0; q = -1; r = -1; dz = -1; after_done = 1;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = W'(a); bus.divisor = W'(b);
    for (int k = 1; k <= W + 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = k; q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero;
        break;
      end
    end
    @(negedge clk);
    after_done = bus.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", bus.done); end
    checks++; if (bus.quotient !== 8'd0) begin errors++; $display("FAIL reset_quot got %0d exp 0", bus.quotient); end
    checks++; if (bus.remainder !== 8'd0) begin errors++; $display("FAIL reset_rem got %0d exp 0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %0b exp 0", bus.div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bn, q, r, dz, ad;
    do_div(100, 7, lat, bn, q, r, dz, ad);
    checks++; if (lat != 9) begin errors++; $display("FAIL basic_latency got %0d exp 9", lat); end
    checks++; if (bn != 8) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 8", bn); end
    checks++; if (q != 14) begin errors++; $display("FAIL basic_quot got %0d exp 14", q); end
    checks++; if (r != 2) begin errors++; $display("FAIL basic_rem got %0d exp 2", r); end
    checks++; if (dz != 0) begin errors++; $display("FAIL basic_dbz got %0d exp 0", dz); end
    checks++; if (ad != 0) begin errors++; $display("FAIL basic_done_width got %0d exp 0", ad); end
  endtask

  task automatic test_corners();
    int av[5] = '{255, 5, 255, 0, 128};
    int bv[5] = '{1, 9, 255, 5, 255};
    int eq[5] = '{255, 0, 1, 0, 0};
    int er[5] = '{0, 5, 0, 0, 128};
    int lat, bn, q, r, dz, ad;
    for (int i = 0; i < 5; i++) begin
      do_div(av[i], bv[i], lat, bn, q, r, dz, ad);
      checks++; if (q != eq[i] || r != er[i] || lat != 9)
        begin errors++; $display("FAIL corner_%0d_%0d got q=%0d r=%0d lat=%0d exp q=%0d r=%0d lat=9",
                                 av[i], bv[i], q, r, lat, eq[i], er[i]); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bn, q, r, dz, ad;
    do_div(42, 0, lat, bn, q, r, dz, ad);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency got %0d exp 1", lat); end
    checks++; if (bn != 0) begin errors++; $display("FAIL dz_busy got %0d exp 0", bn); end
    checks++; if (q != 255 || r != 42) begin errors++; $display("FAIL dz_result got q=%0d r=%0d exp q=255 r=42", q, r); end
    checks++; if (dz != 1) begin errors++; $display("FAIL dz_flag got %0d exp 1", dz); end
    do_div(9, 3, lat, bn, q, r, dz, ad);
    checks++; if (q != 3 || r != 0) begin errors++; $display("FAIL dz_follow got q=%0d r=%0d exp q=3 r=0", q, r); end
    checks++; if (dz != 0) begin errors++; $display("FAIL dz_clear got %0d exp 0", dz); end
  endtask

  task automatic test_busy_ignore();
    int pulses = 0, q = -1, r = -1, lat = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd13;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++; if (lat < 0) begin lat = k; q = bus.quotient; r = bus.remainder; end
      end
      case (k)
        1: bus.start = 1'b0;
        2: begin bus.start = 1'b1; bus.dividend = 8'd10; bus.divisor = 8'd2; end
        3: begin bus.start = 1'b0; bus.dividend = 8'd77; bus.divisor = 8'd5; end
        default: ;
      endcase
    end
    checks++; if (q != 15 || r != 5) begin errors++; $display("FAIL ignore_result got q=%0d r=%0d exp q=15 r=5", q, r); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses got %0d exp 1", pulses); end
    checks++; if (lat != 9) begin errors++; $display("FAIL ignore_latency got %0d exp 9", lat); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0, lat, bn, q, r, dz, ad;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (bus.done) pulses++;
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        checks++; if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0)
          begin errors++; $display("FAIL midrst_outputs got busy=%0b done=%0b q=%0d r=%0d dz=%0b exp all 0",
                                   bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero); end
        rst = 1'b0;
      end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL midrst_pulses got %0d exp 0", pulses); end
    do_div(100, 7, lat, bn, q, r, dz, ad);
    checks++; if (q != 14 || r != 2 || lat != 9)
      begin errors++; $display("FAIL midrst_redo got q=%0d r=%0d lat=%0d exp q=14 r=2 lat=9", q, r, lat); end
  endtask

  task automatic test_back_to_back();
    int q1 = -1, r1 = -1, q2 = -1, r2 = -1, stage = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd60; bus.divisor = 8'd7;
    for (int k = 1; k <= 30 && stage < 4; k++) begin
      @(negedge clk);
      if (stage == 0) begin bus.start = 1'b0; stage = 1; end
      else if (stage == 1 && bus.done) begin
        q1 = bus.quotient; r1 = bus.remainder;
        bus.start = 1'b1; bus.dividend = 8'd81; bus.divisor = 8'd9; stage = 2;
      end else if (stage == 2) begin
        stage = 3;
      end else if (stage == 3) begin
        bus.start = 1'b0;
        if (bus.done) begin q2 = bus.quotient; r2 = bus.remainder; stage = 4; end
      end
    end
    checks++; if (q1 != 8 || r1 != 4) begin errors++; $display("FAIL b2b_first got q=%0d r=%0d exp q=8 r=4", q1, r1); end
    checks++; if (q2 != 9 || r2 != 0) begin errors++; $display("FAIL b2b_second got q=%0d r=%0d exp q=9 r=0", q2, r2); end
    bus.start = 1'b0;
  endtask

  task automatic test_random();
    int a, b, lat, bn, q, r, dz, ad, eq, er, edz, elat;
    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = (i % 50 == 0) ? 0 : int'($urandom_range(0, 255));
      model(a, b, eq, er, edz, elat);
      do_div(a, b, lat, bn, q, r, dz, ad);
      checks++; if (q != eq || r != er || dz != edz)
        begin errors++; $display("FAIL rand_result %0d/%0d got q=%0d r=%0d dz=%0d exp q=%0d r=%0d dz=%0d",
                                 a, b, q, r, dz, eq, er, edz); end
      checks++; if (lat != elat || ad != 0)
        begin errors++; $display("FAIL rand_timing %0d/%0d got lat=%0d after=%0d exp lat=%0d after=0",
                                 a, b, lat, ad, elat); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
